// File: rtl/bit_stream_aligner_16to32_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_stream_aligner_16to32_seq_pkg
// Description : Shared widths and helpers for the 16-to-32 bit-stream aligner.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_stream_aligner_16to32_seq_pkg;

    localparam int IN_WIDTH  = 16;
    localparam int WIN_WIDTH = 32;
    localparam int CMD_WIDTH = 4;
    localparam int LEN_WIDTH = 5;
    localparam int MAX_LEN   = 16;

    // Lengths beyond one word behave as a full-word consume.
    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        if (len > LEN_WIDTH'(MAX_LEN)) begin
            return LEN_WIDTH'(MAX_LEN);
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_stream_aligner_16to32_seq.sv
`default_nettype none
// ============================================================================
// Module      : bit_stream_aligner_16to32_seq
// Description : Two-word bit buffer presenting a 32-bit window plus offset
//               command for a downstream 32-to-16 selector.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_stream_aligner_16to32_seq
    import bit_stream_aligner_16to32_seq_pkg::*;
#(
    parameter int IN_WIDTH  = bit_stream_aligner_16to32_seq_pkg::IN_WIDTH,
    parameter int CMD_WIDTH = bit_stream_aligner_16to32_seq_pkg::CMD_WIDTH,
    parameter int LEN_WIDTH = bit_stream_aligner_16to32_seq_pkg::LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic [IN_WIDTH-1:0]  i_data_bus,
    output logic                 o_ready,
    input  logic                 i_consume,
    input  logic [LEN_WIDTH-1:0] i_len,
    output logic                 o_valid,
    output logic [WIN_WIDTH-1:0] o_data_bus,
    output logic [CMD_WIDTH-1:0] o_cmd
);

    logic [IN_WIDTH-1:0]  r_lo;
    logic [IN_WIDTH-1:0]  r_hi;
    logic [1:0]           r_wcnt;
    logic [CMD_WIDTH-1:0] r_ptr;

    logic [IN_WIDTH-1:0]  w_lo_nxt;
    logic [IN_WIDTH-1:0]  w_hi_nxt;
    logic [1:0]           w_wcnt_nxt;
    logic [CMD_WIDTH-1:0] w_ptr_nxt;

    logic                 w_full;
    logic                 w_valid;
    logic [IN_WIDTH-1:0]  w_hi_eff;
    logic [LEN_WIDTH-1:0] w_len;
    logic [LEN_WIDTH-1:0] w_sum;
    logic                 w_consume;
    logic                 w_retire;
    logic                 w_ready;
    logic                 w_accept;

    assign w_full    = (r_wcnt == 2'd2);
    assign w_valid   = ~rst & i_en & (w_full | ((r_wcnt == 2'd1) & (r_ptr == '0)));
    assign w_hi_eff  = w_full ? r_hi : '0;

    assign w_len     = clamp_len(i_len);
    assign w_sum     = LEN_WIDTH'(r_ptr) + w_len;
    assign w_consume = i_consume & w_valid & (w_len != '0);
    assign w_retire  = w_consume & (w_sum >= LEN_WIDTH'(IN_WIDTH));

    // Ready may rise while full, provided lo frees up on this same edge.
    assign w_ready   = ~rst & i_en & ~i_flush & (~w_full | w_retire);
    assign w_accept  = w_ready & i_valid;

    assign o_ready    = w_ready;
    assign o_valid    = w_valid;
    assign o_data_bus = w_valid ? {w_hi_eff[IN_WIDTH-2:0], r_lo, 1'b0} : '0;
    assign o_cmd      = w_valid ? r_ptr : '0;

    always_comb begin
        w_lo_nxt   = r_lo;
        w_hi_nxt   = r_hi;
        w_wcnt_nxt = r_wcnt;
        w_ptr_nxt  = r_ptr;
        if (i_flush) begin
            w_wcnt_nxt = 2'd0;
            w_ptr_nxt  = '0;
        end else begin
            if (w_consume) begin
                if (w_retire) begin
                    w_lo_nxt   = r_hi;
                    w_wcnt_nxt = r_wcnt - 2'd1;
                    w_ptr_nxt  = CMD_WIDTH'(w_sum - LEN_WIDTH'(IN_WIDTH));
                end else begin
                    w_ptr_nxt  = CMD_WIDTH'(w_sum);
                end
            end
            // Incoming chunk lands in the lowest slot left empty after any retire.
            if (w_accept) begin
                if (w_wcnt_nxt == 2'd0) begin
                    w_lo_nxt = i_data_bus;
                end else begin
                    w_hi_nxt = i_data_bus;
                end
                w_wcnt_nxt = w_wcnt_nxt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo   <= '0;
            r_hi   <= '0;
            r_wcnt <= 2'd0;
            r_ptr  <= '0;
        end else if (i_en) begin
            r_lo   <= w_lo_nxt;
            r_hi   <= w_hi_nxt;
            r_wcnt <= w_wcnt_nxt;
            r_ptr  <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_stream_aligner_16to32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_stream_aligner_16to32_seq
// Description : Scoreboard bench with a bit-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_stream_aligner_16to32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic        i_flush;
    logic        i_valid;
    logic [15:0] i_data_bus;
    logic        o_ready;
    logic        i_consume;
    logic [4:0]  i_len;
    logic        o_valid;
    logic [31:0] o_data_bus;
    logic [3:0]  o_cmd;

    always #5 clk = ~clk;

    bit_stream_aligner_16to32_seq dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .o_ready    (o_ready),
        .i_consume  (i_consume),
        .i_len      (i_len),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_cmd      (o_cmd)
    );

    typedef struct {
        logic        v;
        logic        r;
        logic [31:0] d;
        logic [3:0]  c;
    } exp_t;

    exp_t sb[$];
    bit   mbits[$];
    int   mp;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int mlen();
        int l = int'(i_len);
        if (l > 16) l = 16;
        return l;
    endfunction

    function automatic bit m_valid();
        return !rst && i_en && ((mbits.size() - mp) >= 16);
    endfunction

    function automatic bit m_consume();
        return m_valid() && i_consume && (mlen() != 0);
    endfunction

    function automatic bit m_ready();
        bit retire = m_consume() && ((mp + mlen()) >= 16);
        return !rst && i_en && !i_flush && ((mbits.size() < 32) || retire);
    endfunction

    function automatic exp_t m_outputs();
        exp_t e;
        e.v = m_valid();
        e.r = m_ready();
        e.d = '0;
        e.c = '0;
        if (e.v) begin
            for (int i = 0; i < 31; i++) begin
                if (i < mbits.size()) e.d[i+1] = mbits[i];
            end
            e.c = 4'(mp);
        end
        return e;
    endfunction

    function automatic logic [15:0] field();
        logic [31:0] b = o_data_bus;
        int idx = int'(o_cmd) + 1;
        return b[idx +: 16];
    endfunction

    // Drive inputs, let outputs settle, then score them against the model.
    task automatic drive(input bit r, input bit en, input bit fl, input bit v,
                         input logic [15:0] d, input bit cons, input logic [4:0] len);
        exp_t e;
        exp_t got;
        rst = r; i_en = en; i_flush = fl; i_valid = v;
        i_data_bus = d; i_consume = cons; i_len = len;
        #1;
        sb.push_back(m_outputs());
        e = sb.pop_front();
        got.v = o_valid; got.r = o_ready; got.d = o_data_bus; got.c = o_cmd;
        check("sb_valid", {31'b0, got.v}, {31'b0, e.v});
        check("sb_ready", {31'b0, got.r}, {31'b0, e.r});
        check("sb_data", got.d, e.d);
        check("sb_cmd", {28'b0, got.c}, {28'b0, e.c});
    endtask

    task automatic tick();
        bit acc = m_ready() && i_valid;
        bit cons = m_consume();
        int l = mlen();
        @(posedge clk);
        if (rst || (i_en && i_flush)) begin
            mbits.delete();
            mp = 0;
        end else if (i_en) begin
            if (cons) begin
                mp += l;
                if (mp >= 16) begin
                    for (int i = 0; i < 16; i++) void'(mbits.pop_front());
                    mp -= 16;
                end
            end
            if (acc) begin
                for (int i = 0; i < 16; i++) mbits.push_back(i_data_bus[i]);
            end
        end
        #1;
    endtask

    task automatic cyc(input bit r, input bit en, input bit fl, input bit v,
                       input logic [15:0] d, input bit cons, input logic [4:0] len);
        drive(r, en, fl, v, d, cons, len);
        tick();
    endtask

    initial begin
        mp = 0;
        // Reset state, outputs zero while reset held
        cyc(1, 1, 0, 1, 16'hFFFF, 1, 5'd4);
        drive(1, 1, 0, 1, 16'hFFFF, 1, 5'd4);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_ready", {31'b0, o_ready}, 32'd0);
        check("rst_data", o_data_bus, 32'd0);
        tick();

        // Two chunks, no consume
        cyc(0, 1, 0, 1, 16'hAAAA, 0, 5'd0);
        cyc(0, 1, 0, 1, 16'h5555, 0, 5'd0);
        drive(0, 1, 0, 1, 16'hFFFF, 0, 5'd0);
        check("full_valid", {31'b0, o_valid}, 32'd1);
        check("full_cmd", {28'b0, o_cmd}, 32'd0);
        check("full_field", {16'b0, field()}, 32'h0000AAAA);
        check("full_ready", {31'b0, o_ready}, 32'd0);
        tick();

        // len=0 is no consume
        cyc(0, 1, 0, 0, 16'h0, 1, 5'd0);
        drive(0, 1, 0, 0, 16'h0, 0, 5'd0);
        check("len0_cmd", {28'b0, o_cmd}, 32'd0);
        tick();

        // Consume 4
        cyc(0, 1, 0, 0, 16'h0, 1, 5'd4);
        drive(0, 1, 0, 0, 16'h0, 0, 5'd0);
        check("c4_cmd", {28'b0, o_cmd}, 32'd4);
        check("c4_field", {16'b0, field()}, 32'h00005AAA);
        tick();

        // P=12, consume 8 with simultaneous accept
        cyc(0, 1, 0, 0, 16'h0, 1, 5'd8);
        drive(0, 1, 0, 1, 16'h1234, 1, 5'd8);
        check("ret_ready", {31'b0, o_ready}, 32'd1);
        tick();
        drive(0, 1, 0, 0, 16'h0, 0, 5'd0);
        check("ret_valid", {31'b0, o_valid}, 32'd1);
        check("ret_cmd", {28'b0, o_cmd}, 32'd4);
        check("ret_field", {16'b0, field()}, 32'h00004555);
        check("ret_ready_full", {31'b0, o_ready}, 32'd0);
        tick();

        // Down to W=1,P=0, then consume 16 empties the buffer
        cyc(0, 1, 0, 0, 16'h0, 1, 5'd12);
        drive(0, 1, 0, 0, 16'h0, 0, 5'd0);
        check("w1_field", {16'b0, field()}, 32'h00001234);
        tick();
        cyc(0, 1, 0, 0, 16'h0, 1, 5'd16);
        drive(0, 1, 0, 0, 16'h0, 0, 5'd0);
        check("empty_valid", {31'b0, o_valid}, 32'd0);
        check("empty_data", o_data_bus, 32'd0);
        tick();

        // Enable low freezes, then flush clears
        cyc(0, 1, 0, 1, 16'hBEEF, 0, 5'd0);
        cyc(0, 1, 0, 1, 16'hCAFE, 0, 5'd0);
        drive(0, 0, 0, 1, 16'h1111, 1, 5'd3);
        check("dis_ready", {31'b0, o_ready}, 32'd0);
        check("dis_valid", {31'b0, o_valid}, 32'd0);
        tick();
        drive(0, 1, 0, 0, 16'h0, 0, 5'd0);
        check("dis_hold", {16'b0, field()}, 32'h0000BEEF);
        tick();
        cyc(0, 1, 1, 1, 16'h2222, 1, 5'd3);
        drive(0, 1, 0, 0, 16'h0, 0, 5'd0);
        check("flush_valid", {31'b0, o_valid}, 32'd0);
        tick();
        cyc(0, 1, 0, 1, 16'h3C3C, 0, 5'd0);
        drive(0, 1, 0, 0, 16'h0, 0, 5'd0);
        check("flush_p0", {16'b0, field()}, 32'h00003C3C);
        tick();

        // Reset mid-stream at W=2,P=7
        cyc(0, 1, 0, 1, 16'h7777, 0, 5'd0);
        cyc(0, 1, 0, 0, 16'h0, 1, 5'd7);
        cyc(1, 1, 0, 1, 16'h9999, 1, 5'd2);
        drive(1, 1, 0, 0, 16'h0, 0, 5'd0);
        check("mrst_data", o_data_bus, 32'd0);
        check("mrst_cmd", {28'b0, o_cmd}, 32'd0);
        tick();

        // Length 20 clamps to 16
        cyc(0, 1, 0, 1, 16'hF0F0, 0, 5'd0);
        cyc(0, 1, 0, 1, 16'h0F0F, 0, 5'd0);
        cyc(0, 1, 0, 0, 16'h0, 1, 5'd20);
        drive(0, 1, 0, 0, 16'h0, 0, 5'd0);
        check("clamp_cmd", {28'b0, o_cmd}, 32'd0);
        check("clamp_field", {16'b0, field()}, 32'h00000F0F);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 99) < 2,
                $urandom_range(0, 9) != 0,
                $urandom_range(0, 49) == 0,
                $urandom_range(0, 2) != 0,
                16'($urandom),
                $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 20)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
